// File: rtl/wallace_mul_pipe.sv
// Pipelined Baugh-Wooley / Wallace-tree multiplier with valid/ready handshake and sideband tag.
// Defining WALLACE_MUL_OVF_EN adds the out_ovf flag (product does not fit in WIDTH bits).
module wallace_mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
`ifdef WALLACE_MUL_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH;
  localparam int NG = STAGES - 1;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int rows_after(input int levels);
    int r;
    r = NR;
    for (int k = 0; k < levels; k++) r = r - r / 3;
    return r;
  endfunction

  function automatic int count_levels();
    int r;
    int l;
    r = NR;
    l = 0;
    while (r > 2) begin
      r = r - r / 3;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = count_levels();
  localparam int LPS    = (LEVELS + NG - 1) / NG;

  // One 3:2 level: each full triple becomes sum+carry, leftover rows pass straight through.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    ng;
    o  = '0;
    ng = n / 3;
    for (int g = 0; g < NR / 3; g++) begin
      if (g < ng) begin
        o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      end
    end
    for (int k = 0; k < NR; k++) begin
      if (k >= 3 * ng && k < n) o[k-ng] = r[k];
    end
    return o;
  endfunction

  function automatic rows_t reduce_group(input rows_t r, input int n_in, input int cnt);
    rows_t o;
    int    n;
    o = r;
    n = n_in;
    for (int k = 0; k < LPS; k++) begin
      if (k < cnt) begin
        o = csa_level(o, n);
        n = n - n / 3;
      end
    end
    return o;
  endfunction

  function automatic logic [PW-1:0] add_rows(input rows_t r);
    return r[0] + r[1];
  endfunction

  rows_t             pp;
  rows_t             grp_in   [NG];
  rows_t             grp_out  [NG];
  rows_t             stg_rows [NG];
  logic [STAGES-1:0] stg_valid;
  logic [TAG_W-1:0]  stg_tag  [STAGES];
  logic [PW-1:0]     prod_q;
  logic [PW-1:0]     sum_last;
  logic              stall;

  // Baugh-Wooley: in signed mode the cross terms with exactly one MSB are inverted,
  // and the correction 1s at columns WIDTH and 2*WIDTH-1 ride in the empty top of row 0.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (in_a[j] & in_b[i]) ^ (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp[0][WIDTH] = in_signed;
    pp[0][PW-1]  = in_signed;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int FIRST = g * LPS;
    localparam int CNT   = (FIRST >= LEVELS) ? 0 :
                           ((LEVELS - FIRST < LPS) ? (LEVELS - FIRST) : LPS);
    if (g == 0) begin : g_src
      assign grp_in[g] = pp;
    end else begin : g_src
      assign grp_in[g] = stg_rows[g-1];
    end
    assign grp_out[g] = reduce_group(grp_in[g], rows_after(FIRST), CNT);
  end

  assign sum_last    = add_rows(stg_rows[NG-1]);
  assign out_valid   = stg_valid[STAGES-1];
  assign stall       = out_valid & ~out_ready;
  assign in_ready    = ~stall;
  assign out_product = prod_q;
  assign out_tag     = stg_tag[STAGES-1];

  // Payload only moves with a valid op, so bubbles never disturb the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      prod_q    <= '0;
      for (int s = 0; s < NG; s++) stg_rows[s] <= '0;
      for (int s = 0; s < STAGES; s++) stg_tag[s] <= '0;
    end else if (!stall) begin
      stg_valid <= {stg_valid[STAGES-2:0], in_valid};
      if (in_valid) begin
        stg_rows[0] <= grp_out[0];
        stg_tag[0]  <= in_tag;
      end
      for (int s = 1; s < NG; s++) begin
        if (stg_valid[s-1]) begin
          stg_rows[s] <= grp_out[s];
          stg_tag[s]  <= stg_tag[s-1];
        end
      end
      if (stg_valid[STAGES-2]) begin
        prod_q              <= sum_last;
        stg_tag[STAGES-1]   <= stg_tag[STAGES-2];
      end
    end
  end

`ifdef WALLACE_MUL_OVF_EN
  logic [NG-1:0] stg_signed;
  logic          ovf_q;

  function automatic logic product_ovf(input logic [PW-1:0] p, input logic s);
    return s ? !((&p[PW-1:WIDTH-1]) | ~(|p[PW-1:WIDTH-1])) : (|p[PW-1:WIDTH]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_signed <= '0;
      ovf_q      <= 1'b0;
    end else if (!stall) begin
      if (in_valid) stg_signed[0] <= in_signed;
      for (int s = 1; s < NG; s++) begin
        if (stg_valid[s-1]) stg_signed[s] <= stg_signed[s-1];
      end
      if (stg_valid[STAGES-2]) ovf_q <= product_ovf(sum_last, stg_signed[NG-1]);
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench for wallace_mul_pipe: directed corner cases plus a random
// handshake stream checked against an arithmetic reference queue.
module tb_wallace_mul_pipe;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int TW = 5;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_product;
  logic [TW-1:0]   out_tag;
`ifdef WALLACE_MUL_OVF_EN
  logic            out_ovf;
`endif

  wallace_mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
`ifdef WALLACE_MUL_OVF_EN
    ,
    .out_ovf     (out_ovf)
`endif
  );

  typedef struct {
    logic [2*W-1:0] p;
    logic [TW-1:0]  tag;
    logic           ovf;
  } exp_t;

  exp_t           exp_q[$];
  int             n_chk   = 0;
  int             n_pass  = 0;
  int             acc_cnt = 0;
  int             out_cnt = 0;
  logic           last_acc   = 1'b0;
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_prod  = '0;
  logic [TW-1:0]  prev_tag   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [TW-1:0] t);
    exp_t           e;
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    logic [2*W-1:0] p;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = xa * xb;
    e.p   = p;
    e.tag = t;
    e.ovf = s ? ((p[2*W-1:W-1] != '0) && (p[2*W-1:W-1] != '1)) : (p[2*W-1:W] != '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Scoreboard: consume on out handshake, record on in handshake, watch stall stability.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      last_acc   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_product", out_product, prev_prod);
        chk("hold_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("product", out_product, e.p);
          chk("tag", out_tag, e.tag);
`ifdef WALLACE_MUL_OVF_EN
          chk("ovf", out_ovf, e.ovf);
`endif
          out_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_product;
      prev_tag   = out_tag;
      last_acc   = in_valid && in_ready;
      if (last_acc) begin
        exp_q.push_back(model(in_a, in_b, in_signed, in_tag));
        acc_cnt++;
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [TW-1:0] t);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin : main
    int n;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", out_product, 0);
    chk("rst_tag", out_tag, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // unsigned max*max, latency
    drive('1, '1, 1'b0, 5'd7);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, S);
    chk("umax_product", out_product, 64'hFFFF_FFFE_0000_0001);
    chk("umax_tag", out_tag, 7);
    idle(3);

    // signed min*min then signed -1*3 back-to-back
    drive(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd1);
    drive(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 5'd2);
    idle(2);
    chk("smin_valid", out_valid, 1);
    chk("smin_product", out_product, 64'h4000_0000_0000_0000);
    chk("smin_tag", out_tag, 1);
    idle(1);
    chk("sneg_valid", out_valid, 1);
    chk("sneg_product", out_product, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sneg_tag", out_tag, 2);
    idle(1);
    chk("bubble_after_pair", out_valid, 0);

    drive('0, '0, 1'b0, 5'd3);
    drive('0, 32'h1234_5678, 1'b1, 5'd4);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd5);
    idle(6);
    chk("directed_drained", exp_q.size(), 0);

    // backpressure: out_ready low while input keeps offering
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || last_acc) begin
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        in_signed = 1'($urandom_range(0, 1));
        in_tag    = TW'($urandom);
      end
      chk($sformatf("stall_in_ready_%0d", k), in_ready, k < S);
      @(posedge clk);
      #1;
    end
    chk("stall_queued", exp_q.size(), S);
    chk("stall_out_valid", out_valid, 1);
    drain("stall_drained");
    idle(2);

    // asynchronous reset with a result on the output and more in flight
    out_ready = 1'b1;
    drive($urandom, $urandom, 1'b0, 5'd10);
    drive($urandom, $urandom, 1'b1, 5'd11);
    drive($urandom, $urandom, 1'b0, 5'd12);
    drive($urandom, $urandom, 1'b1, 5'd13);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_product", out_product, 0);
    chk("async_rst_tag", out_tag, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("no_stale_%0d", k), out_valid, 0);
      idle(1);
    end
    chk("post_rst_product", out_product, 0);
    chk("post_rst_ready", in_ready, 1);

    // random stream with random backpressure
    acc_cnt = 0;
    out_cnt = 0;
    for (int cyc = 0; cyc < 20000 && acc_cnt < 1000; cyc++) begin
      if (!in_valid || last_acc) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_a      = pick();
        in_b      = pick();
        in_signed = 1'($urandom_range(0, 1));
        in_tag    = TW'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain("random_drained");
    chk("random_accepted", acc_cnt, 1000);
    chk("random_delivered", out_cnt, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
